// File: rtl/heater_pkg.sv
// rtl/heater_pkg.sv - shared encodings and constants for the heater reconfigurable module
package heater_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } heater_state_e;

  // reg_1 field layout
  localparam int ACT_LSB   = 0;
  localparam int ACT_W     = 4;
  localparam int STATE_LSB = 4;
  localparam int STATE_W   = 2;
  localparam int BUSY_BIT  = 6;
  localparam int HB_BIT    = 7;
  localparam int CSUM_LSB  = 8;
  localparam int FOLD_W    = 24;

  // heartbeat toggles once per 2^HB_BITS cycles
  localparam int HB_BITS = 20;

  // right-shifting Galois mask for x^64 + x^63 + x^61 + x^60 + 1; narrower banks use the top bits
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LFSR_SEED = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic heater_state_e classify(input logic [3:0] target, input logic [3:0] active);
    if (target > active)      return ST_UP;
    else if (target < active) return ST_DOWN;
    else if (active == 4'd0)  return ST_IDLE;
    else                      return ST_HOLD;
  endfunction

endpackage

// File: rtl/heater_bank.sv
// rtl/heater_bank.sv - one power-burning Galois LFSR bank with a 24-bit XOR fold
module heater_bank
  import heater_pkg::*;
#(
  parameter int BANK_WIDTH = 64
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              en,
  output logic [FOLD_W-1:0] fold
);

  localparam int NCH = (BANK_WIDTH + FOLD_W - 1) / FOLD_W;
  localparam logic [BANK_WIDTH-1:0] TAPS = LFSR_TAPS[63 -: BANK_WIDTH];
  localparam logic [BANK_WIDTH-1:0] SEED = LFSR_SEED[BANK_WIDTH-1:0];

  logic [BANK_WIDTH-1:0]     lfsr;
  logic [NCH*FOLD_W-1:0]     padded;

  // step the LFSR only while enabled so a disabled bank stops toggling
  always_ff @(posedge Clk) begin
    if (!Reset_n) lfsr <= SEED;
    else if (en)  lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  end

  // fold the bank into 24 bits so every flop feeds the observable checksum
  always_comb begin
    padded = '0;
    padded[BANK_WIDTH-1:0] = lfsr;
    fold = '0;
    for (int c = 0; c < NCH; c++) fold = fold ^ padded[c*FOLD_W +: FOLD_W];
  end

endmodule

// File: rtl/heater_rm.sv
// rtl/heater_rm.sv - heater partition body: request filter, bank ramp FSM, status/checksum register
module heater_rm
  import heater_pkg::*;
#(
  parameter int NUM_BANKS     = 15,
  parameter int BANK_WIDTH    = 64,
  parameter int RAMP_CYCLES   = 1024,
  parameter int STABLE_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] reg_0,
  output logic [31:0] reg_1
);

  localparam int RW = (RAMP_CYCLES > 2) ? $clog2(RAMP_CYCLES) : 1;
  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [RW-1:0] RAMP_LAST   = RW'(RAMP_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    MAX_LVL     = 4'(NUM_BANKS);

  logic [3:0]         sync1, req_s, cand, target, active, act_q;
  logic [SW-1:0]      scnt;
  logic [RW-1:0]      rcnt;
  logic [HB_BITS-1:0] hb_cnt;
  logic               hb, busy_q;
  heater_state_e      state;
  logic [FOLD_W-1:0]  csum_d, csum_q;
  logic [FOLD_W-1:0]  fold [NUM_BANKS];
  logic               unused_reserved;

  assign unused_reserved = ^reg_0[31:4];

  // two-flop synchroniser for the asynchronous level request
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync1 <= '0;
      req_s <= '0;
    end else begin
      sync1 <= reg_0[3:0];
      req_s <= sync1;
    end
  end

  // accept a request only after it has held steady, clamped to the bank count
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cand   <= '0;
      scnt   <= '0;
      target <= '0;
    end else begin
      if (req_s != cand) begin
        cand <= req_s;
        scnt <= '0;
      end else if (scnt != STABLE_LAST) begin
        scnt <= scnt + 1'b1;
      end
      if (scnt == STABLE_LAST) target <= (cand > MAX_LVL) ? MAX_LVL : cand;
    end
  end

  // ramp FSM: one bank per RAMP_CYCLES toward the current target, status registered alongside
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      active <= '0;
      rcnt   <= '0;
      state  <= ST_IDLE;
      act_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= classify(target, active);
      act_q  <= active;
      busy_q <= (target != active);
      if (active == target) begin
        rcnt <= '0;
      end else if (rcnt == RAMP_LAST) begin
        rcnt   <= '0;
        active <= (target > active) ? active + 4'd1 : active - 4'd1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    heater_bank #(.BANK_WIDTH(BANK_WIDTH)) u_bank (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .en      (active > 4'(i)),
      .fold    (fold[i])
    );
  end

  // combine all bank folds into one word so no bank can be optimised away
  always_comb begin
    csum_d = '0;
    for (int i = 0; i < NUM_BANKS; i++) csum_d = csum_d ^ fold[i];
  end

  // register the checksum and run the free-running heartbeat
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      csum_q <= '0;
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else begin
      csum_q <= csum_d;
      hb_cnt <= hb_cnt + 1'b1;
      if (&hb_cnt) hb <= ~hb;
    end
  end

  assign reg_1 = {csum_q, hb, busy_q, state, act_q};

endmodule
